counter: RTL and testbench
==========================

Name: counter

Overview:
- Free-running synchronous binary up-counter with asynchronous active-high reset.
- Advances by one on every rising clock edge while not in reset. Wraps from its maximum value back to zero.
- Provides status flags for terminal count and wrap events, plus a count of completed wraps. Intended as a timebase or event-sequencing primitive inside larger datapaths.

Parameters:
- WIDTH, 8, bit width of count; legal range 2..32.
- MAX_COUNT, 2**WIDTH-1, terminal value; count wraps (or saturates) after reaching it; must be <= 2**WIDTH-1 and >= 1.
- SATURATE, 0, 0 = wrap MAX_COUNT->0; 1 = hold at MAX_COUNT.
- WRAP_CNT_WIDTH, 8, width of wrap_count.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- count  output  WIDTH  current counter value, registered
- tc  output  1  terminal count: high while count == MAX_COUNT (combinational decode of the count register)
- wrap  output  1  registered one-cycle pulse, high in the cycle after count transitions MAX_COUNT->0
- wrap_count  output  WRAP_CNT_WIDTH  number of wraps since reset; itself wraps modulo 2**WRAP_CNT_WIDTH

Behaviour:
- Reset:
  - reset high forces count=0, wrap=0 and wrap_count=0 immediately, without waiting for a clock edge.
  - Outputs hold these values while reset stays high, including across clock edges.
  - tc reflects count, so it is 0 during reset unless MAX_COUNT==0, which is illegal.
- Release:
  - Deassertion is sampled by the flops. The first rising edge with reset low produces count=1.
  - Outputs hold at reset values until that edge.
- Counting:
  - Each rising edge with reset low: if count != MAX_COUNT, count <= count+1.
  - If count == MAX_COUNT and SATURATE=0: count <= 0, wrap <= 1, wrap_count <= wrap_count+1.
  - If count == MAX_COUNT and SATURATE=1: count holds at MAX_COUNT, wrap stays 0, wrap_count unchanged.
  - On every other edge, wrap <= 0, so wrap is never high for two consecutive cycles.
- Arithmetic:
  - Unsigned, modulo 2**WIDTH. No X propagation from internal state after reset.
  - wrap_count rolls over from 2**WRAP_CNT_WIDTH-1 to 0 silently.
- Mid-operation reset:
  - Reset asserted at any count value, including MAX_COUNT on the same edge as a wrap, clears all state.
  - Reset takes priority over increment and wrap.
- Latency:
  - count updates with 1-cycle latency from the edge.
  - tc is valid in the same cycle count == MAX_COUNT.
  - wrap is asserted in the cycle where count == 0 following the wrap.
- Reset glitch shorter than a clock period still clears state (asynchronous).
- No enable, load or direction inputs; the counter runs whenever reset is low.

Test Plan:
- Clock period 10 ns, first rising edge at 5 ns. Hold reset high 0–10 ns; edge at 5 ns -> count=0. Release at 10 ns -> count=1 after the 15 ns edge, incrementing by 1 per edge.
- Run 10 edges after release (15..105 ns) -> count=10 at 105 ns. Assert reset at 110 ns -> count=0 immediately, before the 115 ns edge, and it stays 0 through that edge.
- Release reset at 120 ns and run 20 edges (125..315 ns) -> count=20 at 320 ns. tc=0 and wrap=0 throughout.
- WIDTH=8 default, run 256 edges from reset:
  - count=255 with tc=1 on the 255th edge.
  - Next edge gives count=0, wrap=1 for exactly one cycle, wrap_count=1.
  - Next edge gives count=1, wrap=0.
- SATURATE=1, MAX_COUNT=5 -> count reaches 5, tc=1 and holds at 5 for 10 further edges. wrap stays 0 and wrap_count stays 0.
- MAX_COUNT=3, WRAP_CNT_WIDTH=2 -> sequence 0,1,2,3,0,...; wrap_count goes 1,2,3,0 on successive wraps. Assert reset on the cycle count=3 -> count=0, wrap_count=0, and no wrap pulse follows.

Source files
------------

// File: rtl/counter.sv
// Free-running binary up-counter with terminal-count decode, a one-cycle wrap
// pulse and a modulo tally of completed wraps. Optional saturation at MAX_COUNT.
module counter #(
    parameter int unsigned      WIDTH          = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT      = {WIDTH{1'b1}},
    parameter bit               SATURATE       = 1'b0,
    parameter int unsigned      WRAP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [WIDTH-1:0]          count,
    output logic                      tc,
    output logic                      wrap,
    output logic [WRAP_CNT_WIDTH-1:0] wrap_count
);

    logic [WIDTH-1:0]          r_count;
    logic                      r_wrap;
    logic [WRAP_CNT_WIDTH-1:0] r_wrap_count;
    logic                      w_at_max;

    assign w_at_max = (r_count == MAX_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_wrap       <= 1'b0;
            r_wrap_count <= '0;
        end else begin
            // wrap is only ever set on the MAX_COUNT->0 edge, so it self-clears next edge
            r_wrap <= 1'b0;
            if (!w_at_max) begin
                r_count <= r_count + 1'b1;
            end else if (!SATURATE) begin
                r_count      <= '0;
                r_wrap       <= 1'b1;
                r_wrap_count <= r_wrap_count + 1'b1;
            end
        end
    end

    assign count      = r_count;
    assign tc         = w_at_max;
    assign wrap       = r_wrap;
    assign wrap_count = r_wrap_count;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: three parameterisations checked against an
// edges-since-reset reference model, a vector table, and hand-written corner sequences.
module tb_counter;

    logic       clk;
    logic       rst_def, rst_sat, rst_sml;

    logic [7:0] def_count; logic def_tc, def_wrap; logic [7:0] def_wc;
    logic [7:0] sat_count; logic sat_tc, sat_wrap; logic [7:0] sat_wc;
    logic [3:0] sml_count; logic sml_tc, sml_wrap; logic [1:0] sml_wc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: rising clock edges seen since reset was last high.
    longint n_def = 0, n_sat = 0, n_sml = 0;

    counter u_def (
        .clk(clk), .reset(rst_def), .count(def_count), .tc(def_tc),
        .wrap(def_wrap), .wrap_count(def_wc)
    );

    counter #(.WIDTH(8), .MAX_COUNT(8'd5), .SATURATE(1'b1), .WRAP_CNT_WIDTH(8)) u_sat (
        .clk(clk), .reset(rst_sat), .count(sat_count), .tc(sat_tc),
        .wrap(sat_wrap), .wrap_count(sat_wc)
    );

    counter #(.WIDTH(4), .MAX_COUNT(4'd3), .SATURATE(1'b0), .WRAP_CNT_WIDTH(2)) u_sml (
        .clk(clk), .reset(rst_sml), .count(sml_count), .tc(sml_tc),
        .wrap(sml_wrap), .wrap_count(sml_wc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst_def) if (rst_def) n_def <= 0; else n_def <= n_def + 1;
    always @(posedge clk or posedge rst_sat) if (rst_sat) n_sat <= 0; else n_sat <= n_sat + 1;
    always @(posedge clk or posedge rst_sml) if (rst_sml) n_sml <= 0; else n_sml <= n_sml + 1;

    function automatic longint m_count(longint n, longint mx, bit sat);
        if (sat) return (n > mx) ? mx : n;
        return n % (mx + 1);
    endfunction

    function automatic longint m_wrap(longint n, longint mx, bit sat);
        return (!sat && n > 0 && (n % (mx + 1)) == 0) ? 1 : 0;
    endfunction

    function automatic longint m_wc(longint n, longint mx, bit sat, int wcw);
        if (sat) return 0;
        return (n / (mx + 1)) % (longint'(1) << wcw);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("def.count", def_count, m_count(n_def, 255, 0));
        chk("def.tc",    def_tc,    m_count(n_def, 255, 0) == 255);
        chk("def.wrap",  def_wrap,  m_wrap(n_def, 255, 0));
        chk("def.wc",    def_wc,    m_wc(n_def, 255, 0, 8));
        chk("sat.count", sat_count, m_count(n_sat, 5, 1));
        chk("sat.tc",    sat_tc,    m_count(n_sat, 5, 1) == 5);
        chk("sat.wrap",  sat_wrap,  m_wrap(n_sat, 5, 1));
        chk("sat.wc",    sat_wc,    m_wc(n_sat, 5, 1, 8));
        chk("sml.count", sml_count, m_count(n_sml, 3, 0));
        chk("sml.tc",    sml_tc,    m_count(n_sml, 3, 0) == 3);
        chk("sml.wrap",  sml_wrap,  m_wrap(n_sml, 3, 0));
        chk("sml.wc",    sml_wc,    m_wc(n_sml, 3, 0, 2));
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rst;
        int unsigned cnt;
        bit          tc;
        bit          wrap;
        int unsigned wc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        rst_def = 1'b1;
        rst_sat = 1'b1;
        rst_sml = 1'b1;

        tbl[0] = '{rst: 1'b1, cnt: 0, tc: 1'b0, wrap: 1'b0, wc: 0};
        for (int i = 1; i < 11; i++)
            tbl[i] = '{rst: 1'b0, cnt: i, tc: 1'b0, wrap: 1'b0, wc: 0};

        // Vector table: reset through the 5 ns edge, release at 10 ns, count to 10 by 105 ns.
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            rst_def = tbl[i].rst;
            edge_sample();
            chk("tbl.count", def_count, tbl[i].cnt);
            chk("tbl.tc",    def_tc,    tbl[i].tc);
            chk("tbl.wrap",  def_wrap,  tbl[i].wrap);
            chk("tbl.wc",    def_wc,    tbl[i].wc);
        end

        // Asynchronous clear at 110 ns, visible before the 115 ns edge.
        @(negedge clk);
        rst_def = 1'b1;
        #1;
        chk("async.count", def_count, 0);
        chk("async.wrap",  def_wrap,  0);
        chk("async.wc",    def_wc,    0);
        edge_sample();
        chk("held.count", def_count, 0);

        @(negedge clk);
        rst_def = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            edge_sample();
            chk("run20.count", def_count, k);
            chk("run20.tc",    def_tc,    0);
            chk("run20.wrap",  def_wrap,  0);
        end

        // Full wrap of the default 8-bit counter.
        @(negedge clk); rst_def = 1'b1;
        @(negedge clk); rst_def = 1'b0;
        for (int k = 1; k < 255; k++) begin
            edge_sample();
            check_all();
        end
        edge_sample();
        chk("max.count", def_count, 255);
        chk("max.tc",    def_tc,    1);
        chk("max.wrap",  def_wrap,  0);
        edge_sample();
        chk("wrap.count", def_count, 0);
        chk("wrap.tc",    def_tc,    0);
        chk("wrap.wrap",  def_wrap,  1);
        chk("wrap.wc",    def_wc,    1);
        edge_sample();
        chk("post.count", def_count, 1);
        chk("post.wrap",  def_wrap,  0);
        chk("post.wc",    def_wc,    1);

        // Saturating instance: reaches 5 and holds for 10 more edges.
        @(negedge clk); rst_sat = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            edge_sample();
            chk("satup.count", sat_count, k);
        end
        chk("sat5.tc", sat_tc, 1);
        for (int k = 0; k < 10; k++) begin
            edge_sample();
            chk("sathold.count", sat_count, 5);
            chk("sathold.tc",    sat_tc,    1);
            chk("sathold.wrap",  sat_wrap,  0);
            chk("sathold.wc",    sat_wc,    0);
        end

        // MAX_COUNT=3, 2-bit wrap tally rolls 1,2,3,0.
        @(negedge clk); rst_sml = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            for (int k = 1; k <= 3; k++) begin
                edge_sample();
                chk("sml.seq", sml_count, k);
            end
            chk("sml.tc3", sml_tc, 1);
            edge_sample();
            chk("sml.zero", sml_count, 0);
            chk("sml.pulse", sml_wrap, 1);
            chk("sml.tally", sml_wc, w % 4);
        end
        for (int k = 1; k <= 3; k++) edge_sample();
        chk("sml.at3", sml_count, 3);
        @(negedge clk);
        rst_sml = 1'b1;
        #1;
        chk("sml.rst.count", sml_count, 0);
        chk("sml.rst.wc",    sml_wc,    0);
        edge_sample();
        chk("sml.rst.nowrap", sml_wrap, 0);
        chk("sml.rst.count2", sml_count, 0);
        @(negedge clk); rst_sml = 1'b0;
        edge_sample();
        chk("sml.rel.count", sml_count, 1);
        chk("sml.rel.wrap",  sml_wrap,  0);

        // Random held resets and sub-cycle reset glitches on all three instances.
        for (int c = 0; c < 2000; c++) begin
            int unsigned r_d, r_s, r_m;
            @(negedge clk);
            r_d = $urandom_range(0, 99);
            r_s = $urandom_range(0, 99);
            r_m = $urandom_range(0, 99);
            rst_def = (r_d < 2);
            rst_sat = (r_s < 3);
            rst_sml = (r_m < 3);
            #1;
            if (r_d >= 2 && r_d < 4) rst_def = 1'b1;
            if (r_s >= 3 && r_s < 5) rst_sat = 1'b1;
            if (r_m >= 3 && r_m < 6) rst_sml = 1'b1;
            #2;
            if (r_d >= 2 && r_d < 4) rst_def = 1'b0;
            if (r_s >= 3 && r_s < 5) rst_sat = 1'b0;
            if (r_m >= 3 && r_m < 6) rst_sml = 1'b0;
            edge_sample();
            check_all();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
